// File: rtl/fpu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl_pkg
// Shared FPU issue definitions: operation and exception types, the issue
// sequencer state enum, default execute latencies and the FCSR-writer
// classification used by the RAW-hazard logic.
// -----------------------------------------------------------------------------
package fpu_issue_ctrl_pkg;

  typedef logic [31:0] Inst_t;

  typedef enum logic [4:0] {
    FPU_OP_NOP,
    FPU_OP_ADD,
    FPU_OP_SUB,
    FPU_OP_MUL,
    FPU_OP_DIV,
    FPU_OP_SQRT,
    FPU_OP_COND,
    FPU_OP_CTC,
    FPU_OP_CFC,
    FPU_OP_MOV,
    FPU_OP_MOVF,
    FPU_OP_MOVT,
    FPU_OP_CVTW,
    FPU_OP_CEIL,
    FPU_OP_FLOOR,
    FPU_OP_ROUND,
    FPU_OP_TRUNC,
    FPU_OP_CVTS,
    FPU_OP_NEG,
    FPU_OP_ABS,
    FPU_OP_INVALID
  } FPUOper_t;

  typedef struct packed {
    logic unimpl;
    logic invalid;
    logic div_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } FPUExcept_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } FpuIssueState_t;

  localparam int FPU_LAT_ADDSUB  = 2;
  localparam int FPU_LAT_MUL     = 2;
  localparam int FPU_LAT_DIV     = 6;
  localparam int FPU_LAT_SQRT    = 5;
  localparam int FPU_LAT_COND    = 2;
  localparam int FPU_LAT_DEFAULT = 1;
  localparam int FPU_CNT_W       = 3;

  // Ops that update FCSR/fcc; a following FCSR reader must wait for them.
  function automatic logic fpu_writes_fcsr(input FPUOper_t op);
    case (op)
      FPU_OP_COND, FPU_OP_CTC, FPU_OP_ADD, FPU_OP_SUB, FPU_OP_MUL,
      FPU_OP_DIV, FPU_OP_SQRT, FPU_OP_CVTW, FPU_OP_CEIL, FPU_OP_FLOOR,
      FPU_OP_ROUND, FPU_OP_TRUNC, FPU_OP_CVTS, FPU_OP_NEG,
      FPU_OP_ABS:  return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_lat_table.sv
// -----------------------------------------------------------------------------
// fpu_lat_table
// Combinational op -> execute latency lookup (in cycles, CNT_W bits wide).
// Ports:
//   op  : FPU operation
//   lat : execute latency of op
// -----------------------------------------------------------------------------
module fpu_lat_table
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int LAT_ADDSUB  = FPU_LAT_ADDSUB,
  parameter int LAT_MUL     = FPU_LAT_MUL,
  parameter int LAT_DIV     = FPU_LAT_DIV,
  parameter int LAT_SQRT    = FPU_LAT_SQRT,
  parameter int LAT_COND    = FPU_LAT_COND,
  parameter int LAT_DEFAULT = FPU_LAT_DEFAULT,
  parameter int CNT_W       = FPU_CNT_W
) (
  input  FPUOper_t         op,
  output logic [CNT_W-1:0] lat
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    lat = CNT_W'(LAT_DEFAULT);
    case (op)
      FPU_OP_ADD, FPU_OP_SUB: lat = CNT_W'(LAT_ADDSUB);
      FPU_OP_MUL:             lat = CNT_W'(LAT_MUL);
      FPU_OP_DIV:             lat = CNT_W'(LAT_DIV);
      FPU_OP_SQRT:            lat = CNT_W'(LAT_SQRT);
      FPU_OP_COND:            lat = CNT_W'(LAT_COND);
      default:                lat = CNT_W'(LAT_DEFAULT);
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
// Single-issue sequencer between FPU issue and the FPU execute datapath.
// Accepts one op (req_*), holds it on ex_* for the op's fixed latency, captures
// the datapath result into a hold register and offers it on wb_* until the
// writeback handshake. Stalls issue on FPR RAW and FCSR-reader hazards.
// Ports:
//   clk, rst_n, flush                  : clock, async active-low reset, flush
//   req_valid/req_ready, req_*         : issue handshake and op fields
//   ex_op, ex_inst, ex_start, ex_flush : datapath control
//   ex_ret, ex_cpu_ret, ex_except,
//   ex_fcsr_we                         : datapath results
//   wb_valid/wb_ready, wb_*            : held result to writeback
//   busy                               : op in flight or result held
// -----------------------------------------------------------------------------
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int LAT_ADDSUB  = FPU_LAT_ADDSUB,
  parameter int LAT_MUL     = FPU_LAT_MUL,
  parameter int LAT_DIV     = FPU_LAT_DIV,
  parameter int LAT_SQRT    = FPU_LAT_SQRT,
  parameter int LAT_COND    = FPU_LAT_COND,
  parameter int LAT_DEFAULT = FPU_LAT_DEFAULT,
  parameter int CNT_W       = FPU_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  FPUOper_t    req_op,
  input  Inst_t       req_inst,
  input  logic [4:0]  req_dest,
  input  logic        req_dest_we,
  input  logic [4:0]  req_src1,
  input  logic [4:0]  req_src2,
  input  logic        req_src1_re,
  input  logic        req_src2_re,
  input  logic        req_fcsr_rd,
  output FPUOper_t    ex_op,
  output Inst_t       ex_inst,
  output logic        ex_start,
  output logic        ex_flush,
  input  logic [31:0] ex_ret,
  input  logic [31:0] ex_cpu_ret,
  input  FPUExcept_t  ex_except,
  input  logic        ex_fcsr_we,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_ret,
  output logic [31:0] wb_cpu_ret,
  output FPUExcept_t  wb_except,
  output logic        wb_fcsr_we,
  output logic [4:0]  wb_dest,
  output logic        wb_dest_we,
  output logic        busy
);

  FpuIssueState_t   state_q;
  FPUOper_t         op_q;
  Inst_t            inst_q;
  logic [4:0]       dest_q;
  logic             dest_we_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] req_lat;

  logic in_flight;
  logic hazard;
  logic fire;
  logic retire;

  fpu_lat_table #(
    .LAT_ADDSUB  (LAT_ADDSUB),
    .LAT_MUL     (LAT_MUL),
    .LAT_DIV     (LAT_DIV),
    .LAT_SQRT    (LAT_SQRT),
    .LAT_COND    (LAT_COND),
    .LAT_DEFAULT (LAT_DEFAULT),
    .CNT_W       (CNT_W)
  ) u_lat (
    .op  (req_op),
    .lat (req_lat)
  );

  // A held result that writeback takes this cycle no longer blocks a reader.
  assign in_flight = (state_q == EXEC) || ((state_q == DONE) && !wb_ready);

  assign hazard = in_flight &&
                  ((dest_we_q && req_src1_re && (req_src1 == dest_q)) ||
                   (dest_we_q && req_src2_re && (req_src2 == dest_q)) ||
                   (req_fcsr_rd && fpu_writes_fcsr(op_q)));

  assign req_ready = !flush && !hazard &&
                     ((state_q == IDLE) || ((state_q == DONE) && wb_ready));
  assign fire      = req_valid && req_ready;
  assign retire    = (state_q == DONE) && wb_ready && !flush;

  assign ex_flush  = flush;
  assign ex_inst   = inst_q;
  assign busy      = (state_q != IDLE);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= FPU_OP_NOP;
      inst_q     <= '0;
      dest_q     <= '0;
      dest_we_q  <= 1'b0;
      cnt_q      <= '0;
      ex_op      <= FPU_OP_NOP;
      ex_start   <= 1'b0;
      wb_valid   <= 1'b0;
      wb_ret     <= '0;
      wb_cpu_ret <= '0;
      wb_except  <= '0;
      wb_fcsr_we <= 1'b0;
      wb_dest    <= '0;
      wb_dest_we <= 1'b0;
    end else begin
      // fire is already gated by flush, so a start never follows a flush.
      ex_start <= fire;

      if (flush) begin
        state_q    <= IDLE;
        ex_op      <= FPU_OP_NOP;
        wb_valid   <= 1'b0;
        wb_dest_we <= 1'b0;
        wb_fcsr_we <= 1'b0;
      end else begin
        case (state_q)
          EXEC: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              wb_ret     <= ex_ret;
              wb_cpu_ret <= ex_cpu_ret;
              wb_except  <= ex_except;
              wb_fcsr_we <= ex_fcsr_we;
              wb_dest    <= dest_q;
              wb_dest_we <= dest_we_q;
              wb_valid   <= 1'b1;
              ex_op      <= FPU_OP_NOP;
              state_q    <= DONE;
            end
          end
          DONE: begin
            if (retire) begin
              wb_valid   <= 1'b0;
              wb_dest_we <= 1'b0;
              wb_fcsr_we <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: ;
        endcase

        // Accept from IDLE, or back-to-back from DONE on the retire cycle.
        if (fire) begin
          op_q      <= req_op;
          inst_q    <= req_inst;
          dest_q    <= req_dest;
          dest_we_q <= req_dest_we;
          cnt_q     <= req_lat - 1'b1;
          ex_op     <= req_op;
          state_q   <= EXEC;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_ctrl
// Directed scenarios followed by random traffic, all checked every cycle
// against a timeline model: an op accepted in cycle A with latency L executes
// in cycles A+1..A+L and is held for writeback from cycle A+L+1.
// -----------------------------------------------------------------------------
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  FPUOper_t    req_op;
  Inst_t       req_inst;
  logic [4:0]  req_dest;
  logic        req_dest_we;
  logic [4:0]  req_src1;
  logic [4:0]  req_src2;
  logic        req_src1_re;
  logic        req_src2_re;
  logic        req_fcsr_rd;
  FPUOper_t    ex_op;
  Inst_t       ex_inst;
  logic        ex_start;
  logic        ex_flush;
  logic [31:0] ex_ret;
  logic [31:0] ex_cpu_ret;
  FPUExcept_t  ex_except;
  logic        ex_fcsr_we;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_ret;
  logic [31:0] wb_cpu_ret;
  FPUExcept_t  wb_except;
  logic        wb_fcsr_we;
  logic [4:0]  wb_dest;
  logic        wb_dest_we;
  logic        busy;

  fpu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_inst(req_inst), .req_dest(req_dest), .req_dest_we(req_dest_we),
    .req_src1(req_src1), .req_src2(req_src2), .req_src1_re(req_src1_re),
    .req_src2_re(req_src2_re), .req_fcsr_rd(req_fcsr_rd),
    .ex_op(ex_op), .ex_inst(ex_inst), .ex_start(ex_start), .ex_flush(ex_flush),
    .ex_ret(ex_ret), .ex_cpu_ret(ex_cpu_ret), .ex_except(ex_except),
    .ex_fcsr_we(ex_fcsr_we),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_ret(wb_ret),
    .wb_cpu_ret(wb_cpu_ret), .wb_except(wb_except), .wb_fcsr_we(wb_fcsr_we),
    .wb_dest(wb_dest), .wb_dest_we(wb_dest_we), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one op on a timeline.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_acc;
  int          m_lat;
  FPUOper_t    m_op;
  Inst_t       m_inst;
  logic [4:0]  m_dest;
  logic        m_dest_we;
  logic [31:0] m_ret;
  logic [31:0] m_cpu_ret;
  logic [5:0]  m_except;
  logic        m_fcsr_we;

  FPUOper_t op_list [21] = '{
    FPU_OP_NOP, FPU_OP_ADD, FPU_OP_SUB, FPU_OP_MUL, FPU_OP_DIV, FPU_OP_SQRT,
    FPU_OP_COND, FPU_OP_CTC, FPU_OP_CFC, FPU_OP_MOV, FPU_OP_MOVF, FPU_OP_MOVT,
    FPU_OP_CVTW, FPU_OP_CEIL, FPU_OP_FLOOR, FPU_OP_ROUND, FPU_OP_TRUNC,
    FPU_OP_CVTS, FPU_OP_NEG, FPU_OP_ABS, FPU_OP_INVALID
  };

  function automatic int ref_lat(input FPUOper_t op);
    if (op == FPU_OP_ADD || op == FPU_OP_SUB) return 2;
    if (op == FPU_OP_MUL)  return 2;
    if (op == FPU_OP_DIV)  return 6;
    if (op == FPU_OP_SQRT) return 5;
    if (op == FPU_OP_COND) return 2;
    return 1;
  endfunction

  function automatic bit ref_fcsr_writer(input FPUOper_t op);
    FPUOper_t writers [15] = '{
      FPU_OP_COND, FPU_OP_CTC, FPU_OP_ADD, FPU_OP_SUB, FPU_OP_MUL, FPU_OP_DIV,
      FPU_OP_SQRT, FPU_OP_CVTW, FPU_OP_CEIL, FPU_OP_FLOOR, FPU_OP_ROUND,
      FPU_OP_TRUNC, FPU_OP_CVTS, FPU_OP_NEG, FPU_OP_ABS
    };
    foreach (writers[i]) if (writers[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input bit v, input FPUOper_t op, input int dest,
                         input bit dwe, input int s1, input bit s1re,
                         input int s2, input bit s2re, input bit frd);
    req_valid   = v;
    req_op      = op;
    req_inst    = $urandom;
    req_dest    = 5'(dest);
    req_dest_we = dwe;
    req_src1    = 5'(s1);
    req_src1_re = s1re;
    req_src2    = 5'(s2);
    req_src2_re = s2re;
    req_fcsr_rd = frd;
  endtask

  task automatic idle_req();
    set_req(1'b0, FPU_OP_NOP, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Entered at a negedge with request inputs driven; checks this cycle,
  // advances the model across the coming posedge, returns at the next negedge.
  task automatic run_cycle();
    bit done_m, exec_m, hold, haz, rdy, fire;
    ex_ret     = $urandom;
    ex_cpu_ret = $urandom;
    ex_except  = 6'($urandom);
    ex_fcsr_we = 1'($urandom);
    #1;
    done_m = m_busy && (cyc >= m_acc + m_lat + 1);
    exec_m = m_busy && !done_m;
    hold   = exec_m || (done_m && !wb_ready);
    haz    = hold && ((m_dest_we && req_src1_re && req_src1 == m_dest) ||
                      (m_dest_we && req_src2_re && req_src2 == m_dest) ||
                      (req_fcsr_rd && ref_fcsr_writer(m_op)));
    rdy    = !flush && !haz && (!m_busy || (done_m && wb_ready));
    fire   = req_valid && rdy;

    check("req_ready", 32'(req_ready), 32'(rdy));
    check("ex_flush",  32'(ex_flush),  32'(flush));
    check("busy",      32'(busy),      32'(m_busy));
    check("wb_valid",  32'(wb_valid),  32'(done_m));
    check("ex_start",  32'(ex_start),  32'(m_busy && cyc == m_acc + 1));
    check("ex_op",     32'(ex_op),     exec_m ? 32'(m_op) : 32'(FPU_OP_NOP));
    if (exec_m) check("ex_inst", ex_inst, m_inst);
    if (done_m) begin
      check("wb_ret",     wb_ret,     m_ret);
      check("wb_cpu_ret", wb_cpu_ret, m_cpu_ret);
      check("wb_except",  {26'd0, wb_except}, {26'd0, m_except});
      check("wb_fcsr_we", 32'(wb_fcsr_we), 32'(m_fcsr_we));
      check("wb_dest",    32'(wb_dest),    32'(m_dest));
      check("wb_dest_we", 32'(wb_dest_we), 32'(m_dest_we));
    end

    if (exec_m && cyc == m_acc + m_lat) begin
      m_ret     = ex_ret;
      m_cpu_ret = ex_cpu_ret;
      m_except  = ex_except;
      m_fcsr_we = ex_fcsr_we;
    end
    if (flush || (done_m && wb_ready)) m_busy = 1'b0;
    if (fire) begin
      m_busy    = 1'b1;
      m_acc     = cyc;
      m_op      = req_op;
      m_lat     = ref_lat(req_op);
      m_inst    = req_inst;
      m_dest    = req_dest;
      m_dest_we = req_dest_we;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    idle_req();
    ex_ret = '0; ex_cpu_ret = '0; ex_except = '0; ex_fcsr_we = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst busy",       32'(busy),       32'd0);
    check("rst ex_op",      32'(ex_op),      32'(FPU_OP_NOP));
    check("rst ex_start",   32'(ex_start),   32'd0);
    check("rst wb_valid",   32'(wb_valid),   32'd0);
    check("rst wb_dest_we", 32'(wb_dest_we), 32'd0);
    check("rst wb_fcsr_we", 32'(wb_fcsr_we), 32'd0);
    check("rst wb_ret",     wb_ret,          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with writeback always ready: ex_start, two EXEC cycles, then wb.
    set_req(1'b1, FPU_OP_ADD, 3, 1'b1, 1, 1'b1, 2, 1'b1, 1'b0);
    run_cycle(); idle_req(); run_idle(5);

    // DIV held in DONE by writeback back-pressure, then back-to-back MUL.
    wb_ready = 1'b0;
    set_req(1'b1, FPU_OP_DIV, 7, 1'b1, 1, 1'b1, 2, 1'b1, 1'b0);
    run_cycle();
    set_req(1'b1, FPU_OP_MUL, 8, 1'b1, 9, 1'b1, 10, 1'b1, 1'b0);
    run_idle(18);
    wb_ready = 1'b1;
    run_cycle(); idle_req(); run_idle(4);

    // FPR RAW: MUL reads the ADD destination f4; the f5-only op also waits.
    set_req(1'b1, FPU_OP_ADD, 4, 1'b1, 1, 1'b1, 2, 1'b1, 1'b0);
    run_cycle();
    set_req(1'b1, FPU_OP_MUL, 6, 1'b1, 1, 1'b0, 4, 1'b1, 1'b0);
    wb_ready = 1'b0; run_idle(3);
    set_req(1'b1, FPU_OP_MOV, 6, 1'b1, 5, 1'b1, 0, 1'b0, 1'b0);
    run_idle(2);
    set_req(1'b1, FPU_OP_MUL, 6, 1'b1, 1, 1'b0, 4, 1'b1, 1'b0);
    wb_ready = 1'b1; run_cycle(); idle_req(); run_idle(4);

    // FCSR reader behind a compare, then a plain move behind a compare.
    set_req(1'b1, FPU_OP_COND, 0, 1'b0, 1, 1'b1, 2, 1'b1, 1'b0);
    run_cycle();
    set_req(1'b1, FPU_OP_CFC, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    wb_ready = 1'b0; run_idle(4);
    wb_ready = 1'b1; run_cycle();
    set_req(1'b1, FPU_OP_COND, 0, 1'b0, 1, 1'b1, 2, 1'b1, 1'b0);
    run_idle(2);
    set_req(1'b1, FPU_OP_MOV, 9, 1'b1, 3, 1'b1, 0, 1'b0, 1'b0);
    run_cycle(); idle_req(); run_idle(4);

    // Flush mid-SQRT (counter at 2), then flush in DONE with wb_ready high.
    set_req(1'b1, FPU_OP_SQRT, 2, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0);
    run_cycle(); idle_req(); run_idle(2);
    flush = 1'b1; run_cycle(); flush = 1'b0; run_idle(7);
    set_req(1'b1, FPU_OP_ADD, 2, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0);
    run_cycle(); idle_req(); run_idle(2);
    flush = 1'b1; run_cycle(); flush = 1'b0; run_idle(3);

    // Random traffic with small register ranges so hazards are frequent.
    for (int i = 0; i < 1500; i++) begin
      set_req(($urandom_range(0, 9) < 7), op_list[$urandom_range(0, 20)],
              $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
              1'($urandom), $urandom_range(0, 3), 1'($urandom),
              ($urandom_range(0, 3) == 0));
      wb_ready = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 31) == 0);
      run_cycle();
    end
    flush = 1'b1; idle_req(); run_cycle(); flush = 1'b0; wb_ready = 1'b1;

    // Asynchronous reset in the middle of a DIV, off the clock edge.
    set_req(1'b1, FPU_OP_DIV, 5, 1'b1, 1, 1'b1, 2, 1'b1, 1'b0);
    run_cycle(); idle_req(); run_idle(3);
    #3 rst_n = 1'b0;
    #1;
    check("async rst busy",     32'(busy),     32'd0);
    check("async rst ex_op",    32'(ex_op),    32'(FPU_OP_NOP));
    check("async rst wb_valid", 32'(wb_valid), 32'd0);
    check("async rst ex_start", 32'(ex_start), 32'd0);
    m_busy = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    cyc++;
    set_req(1'b1, FPU_OP_MUL, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
    run_cycle(); idle_req(); run_idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Single-issue sequencer between the FPU decode/issue stage and the FPU execute datapath.
- Accepts one FPU operation at a time via valid/ready and holds op, instruction and destination stable for the op's fixed latency.
- Captures the result and exception flags into a hold register, then presents them to writeback via valid/ready.
- Provides RAW-hazard stall for FPR sources and FCSR readers, and flush handling.

Parameters:
- LAT_ADDSUB, 2, execute cycles for FPU_OP_ADD/FPU_OP_SUB
- LAT_MUL, 2, execute cycles for FPU_OP_MUL
- LAT_DIV, 6, execute cycles for FPU_OP_DIV
- LAT_SQRT, 5, execute cycles for FPU_OP_SQRT
- LAT_COND, 2, execute cycles for FPU_OP_COND
- LAT_DEFAULT, 1, execute cycles for all other ops
- CNT_W, 3, counter width; must hold max(LAT_*)-1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- req_valid  in  1  issue has an FPU op
- req_ready  out  1  op accepted when valid & ready
- req_op  in  FPUOper_t  operation
- req_inst  in  32  instruction word (Inst_t)
- req_dest  in  5  destination FPR
- req_dest_we  in  1  op writes an FPR
- req_src1, req_src2  in  5 each  source FPRs
- req_src1_re, req_src2_re  in  1 each  source read enables
- req_fcsr_rd  in  1  op reads FCSR/fcc (CFC, MOVF/MOVT, BC1x)
- ex_op  out  FPUOper_t  op driven to the datapath; FPU_OP_NOP when idle
- ex_inst  out  32  held instruction
- ex_start  out  1  one-cycle pulse, first execute cycle
- ex_flush  out  1  equals flush
- ex_ret  in  32  datapath FPR result
- ex_cpu_ret  in  32  datapath GPR result
- ex_except  in  FPUExcept_t  datapath exception flags
- ex_fcsr_we  in  1  datapath FCSR write enable
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_ret, wb_cpu_ret  out  32 each  held results
- wb_except  out  FPUExcept_t  held flags
- wb_fcsr_we  out  1  held FCSR write enable
- wb_dest  out  5  held destination
- wb_dest_we  out  1  held destination write enable
- busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-low. All registers clear.
  - State IDLE; ex_op=FPU_OP_NOP; ex_start=0.
  - wb_valid, wb_dest_we and wb_fcsr_we are 0; all wb data is 0; counter is 0.
- States:
  - IDLE: no op in flight.
  - EXEC: op in flight, counter running.
  - DONE: result held for writeback.
- Latency lookup: lat(op) comes from the parameters, resolved at accept.
- Accept (fire = req_valid & req_ready):
  - Latch op, inst, dest and dest_we; cnt <= lat-1; next state EXEC.
  - ex_start=1 in the first EXEC cycle only.
- EXEC:
  - ex_op and ex_inst are held constant.
  - If cnt != 0, decrement.
  - If cnt == 0, capture ex_ret, ex_cpu_ret, ex_except and ex_fcsr_we into the wb registers; next state DONE.
  - Op accepted in cycle T gives wb_valid in cycle T+lat+1.
- DONE:
  - wb_valid=1; ex_op=FPU_OP_NOP.
  - Held values stay stable until wb_valid & wb_ready & ~flush.
  - On that handshake: next state IDLE, or EXEC if a new req fires in the same cycle (back-to-back).
- req_ready = ~flush & ~hazard & (IDLE | (DONE & wb_ready)).
- hazard, evaluated against the in-flight entry (EXEC, or DONE not retiring this cycle):
  - (dest_we & src1_re & src1==dest), or
  - (dest_we & src2_re & src2==dest), or
  - (req_fcsr_rd & in-flight op in {COND, CTC, ADD, SUB, MUL, DIV, SQRT, CVTW, CEIL, FLOOR, ROUND, TRUNC, CVTS, NEG, ABS}).
  - In DONE with wb_ready=1 the in-flight entry retires, so hazard=0.
- flush:
  - Dominates everything.
  - Next state IDLE; wb_valid=0 next cycle; no handshake completes; req_ready=0 in the flush cycle.
  - ex_flush=flush, combinational.
- Reset asserted mid-EXEC/DONE: immediate return to the reset values above; the result is discarded.
- LAT=1 ops: exactly one EXEC cycle, with ex_start and capture in the same cycle.
- FPU_OP_INVALID: sequenced with LAT_DEFAULT. The unimpl flag travels in wb_except.

Decomposition:
- cpu_defs package, new entries:
  - FPU_OP_NOP, if not already present.
  - FpuIssueState_t enum {IDLE, EXEC, DONE}.
  - FPU_LAT_* localparams, used as the defaults.
- Sub-module fpu_lat_table: combinational op -> latency (CNT_W bits).
  - Shared with the hazard logic in issue, which uses it for future dual-issue.

Test Plan:
- FPU_OP_ADD accepted at cycle 10, wb_ready=1 -> ex_start at 11, ex_op=ADD at cycles 11-12, capture at 12, wb_valid=1 only at 13, wb_ret=ex_ret sampled at 12.
- FPU_OP_DIV at 20, wb_ready=0 until 40 -> wb_valid rises at 27 and stays high with constant wb_ret until the handshake at 40; req_ready=0 during 21-39, then 1 at 40 together with a back-to-back MUL accept.
- ADD with dest=f4 in flight, next req MUL with src2=f4, src2_re=1 -> req_ready=0 until the cycle ADD's wb handshakes; the f5-only op during the same window is also stalled (single-issue).
- C.EQ in flight, CFC $25 requested (req_fcsr_rd=1) -> stalled until COND retires; MOV.S with no FCSR read is stalled only by single-issue.
- SQRT in EXEC with cnt=2, flush=1 for one cycle -> state IDLE next cycle, wb_valid never asserts, ex_flush=1 in that cycle; flush during DONE with wb_ready=1 -> no retire.
- rst_n low mid-DIV (async, not clock-aligned) -> busy=0, ex_op=NOP and wb_valid=0 immediately; after release, the first req_valid is accepted on the next edge.
